input_counter: RTL and testbench

Input-side sequencer for the 64-point FFT processor, the loading counterpart of the output sequencer. It accepts a stream of samples through a valid/ready handshake and generates the write address and write strobe for the input buffer. After a full frame of 2^ADDR_W samples it issues a one-cycle `start_fft` pulse, then blocks further input until the FFT core reports completion with `fft_done`.

---
 rtl/input_counter_if.sv | 20 ++
 rtl/input_counter.sv | 55 +++++
 tb/tb_input_counter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/input_counter_if.sv
// input_counter_if: sample-load handshake and input-buffer control bundle for input_counter.
interface input_counter_if #(parameter int ADDR_W = 6);
    logic              din_valid;
    logic              din_ready;
    logic              fft_done;
    logic              wr_en;
    logic              in_ctrl_all_in;
    logic              hold_all_in;
    logic              start_fft;
    logic              drop_err;
    logic [ADDR_W-1:0] counter_o;
    modport master (
        output din_valid, fft_done,
        input  din_ready, wr_en, in_ctrl_all_in, hold_all_in, start_fft, drop_err, counter_o
    );
    modport slave (
        input  din_valid, fft_done,
        output din_ready, wr_en, in_ctrl_all_in, hold_all_in, start_fft, drop_err, counter_o
    );
endinterface

// File: rtl/input_counter.sv
// input_counter: loads one 2^ADDR_W-sample frame, pulses start_fft, then waits for fft_done.
// Define INPUT_BITREV_EN to emit the write address in bit-reversed order.
module input_counter #(
    parameter int ADDR_W = 6
) (
    input logic            clk,
    input logic            rst,
    input_counter_if.slave bus
);
    typedef enum logic [1:0] {LOAD, LAUNCH, BUSY} state_t;
    state_t            state;
    logic [ADDR_W-1:0] count;
    assign bus.wr_en       = bus.din_valid & bus.din_ready;
    assign bus.hold_all_in = ~bus.wr_en;
`ifdef INPUT_BITREV_EN
    for (genvar i = 0; i < ADDR_W; i++) begin : g_rev
        assign bus.counter_o[i] = count[ADDR_W-1-i];
    end
`else
    assign bus.counter_o = count;
`endif
    // the last accept wraps count to zero on its own, so BUSY never needs to clear it
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= LOAD;
            count              <= '0;
            bus.din_ready      <= 1'b1;
            bus.in_ctrl_all_in <= 1'b1;
            bus.start_fft      <= 1'b0;
            bus.drop_err       <= 1'b0;
        end else begin
            bus.start_fft <= 1'b0;
            if (bus.din_valid && !bus.din_ready) bus.drop_err <= 1'b1;
            case (state)
                LOAD: if (bus.wr_en) begin
                    count <= count + ADDR_W'(1);
                    if (&count) begin
                        state              <= LAUNCH;
                        bus.din_ready      <= 1'b0;
                        bus.in_ctrl_all_in <= 1'b0;
                        bus.start_fft      <= 1'b1;
                    end
                end
                LAUNCH: state <= BUSY;
                BUSY: if (bus.fft_done) begin
                    state              <= LOAD;
                    count              <= '0;
                    bus.din_ready      <= 1'b1;
                    bus.in_ctrl_all_in <= 1'b1;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_input_counter.sv
// tb_input_counter: directed and randomized checks of input_counter against a frame-level model.
module tb_input_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    input_counter_if #(.ADDR_W(6)) bus ();
    input_counter #(.ADDR_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // model: phase 0=loading, 1=launch, 2=waiting for the core
    int   m_cnt = 0;
    int   m_ph = 0;
    logic m_drop = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_ph   <= 0;
            m_drop <= 1'b0;
        end else begin
            if (bus.din_valid && m_ph != 0) m_drop <= 1'b1;
            if (m_ph == 0) begin
                if (bus.din_valid) begin
                    if (m_cnt == 63) begin
                        m_cnt <= 0;
                        m_ph  <= 1;
                    end else m_cnt <= m_cnt + 1;
                end
            end else if (m_ph == 1) m_ph <= 2;
            else if (bus.fft_done) m_ph <= 0;
        end
    end

    function automatic logic [5:0] e_addr(int c);
        logic [5:0] a;
        logic [5:0] r;
        a = 6'(c);
        r = a;
`ifdef INPUT_BITREV_EN
        for (int i = 0; i < 6; i++) r[i] = a[5-i];
`endif
        return r;
    endfunction

    task automatic cyc(input logic v, input logic d, input logic r);
        @(negedge clk);
        bus.din_valid = v;
        bus.fft_done  = d;
        rst           = r;
        #1;
    endtask

    task automatic load(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if (bus.din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.din_ready); end
        n_chk++; if (bus.in_ctrl_all_in !== 1'b1) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 1", bus.in_ctrl_all_in); end
        n_chk++; if (bus.start_fft !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", bus.start_fft); end
        n_chk++; if (bus.drop_err !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b expected 0", bus.drop_err); end
        n_chk++; if (bus.wr_en !== 1'b0 || bus.hold_all_in !== 1'b1) begin n_fail++; $display("FAIL reset_wr_hold: got %b%b expected 01", bus.wr_en, bus.hold_all_in); end
        n_chk++; if (bus.counter_o !== 6'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", bus.counter_o); end
    endtask

    task automatic test_back_to_back;
        int wr_cnt = 0;
        int st_cnt = 0;
        for (int k = 0; k < 64; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            wr_cnt += int'(bus.wr_en);
            n_chk++; if (bus.counter_o !== e_addr(k)) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0d expected %0d", k, bus.counter_o, e_addr(k)); end
            n_chk++; if (bus.din_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, bus.din_ready); end
        end
        n_chk++; if (wr_cnt != 64) begin n_fail++; $display("FAIL b2b_wr_count: got %0d expected 64", wr_cnt); end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if (bus.start_fft !== 1'b1 || bus.din_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_launch: got start=%b ready=%b expected 1,0", bus.start_fft, bus.din_ready); end
        st_cnt += int'(bus.start_fft);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
            st_cnt += int'(bus.start_fft);
            n_chk++; if (bus.din_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_ready: got %b expected 0", bus.din_ready); end
        end
        n_chk++; if (st_cnt != 1) begin n_fail++; $display("FAIL b2b_start_count: got %0d expected 1", st_cnt); end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if (bus.din_ready !== 1'b1 || bus.counter_o !== 6'd0) begin n_fail++; $display("FAIL b2b_reload: got ready=%b addr=%0d expected 1,0", bus.din_ready, bus.counter_o); end
    endtask

    task automatic test_gaps;
        int acc = 0;
        for (int k = 0; acc < 64 && k < 400; k++) begin
            logic v;
            v = (k % 3 == 0) || ($urandom_range(0, 3) == 0);
            cyc(v, 1'b0, 1'b0);
            n_chk++; if (bus.counter_o !== e_addr(acc)) begin n_fail++; $display("FAIL gap_addr: got %0d expected %0d", bus.counter_o, e_addr(acc)); end
            n_chk++; if (bus.wr_en !== v || bus.hold_all_in !== !v) begin n_fail++; $display("FAIL gap_wr_hold: got %b%b expected %b%b", bus.wr_en, bus.hold_all_in, v, !v); end
            n_chk++; if (bus.start_fft !== 1'b0) begin n_fail++; $display("FAIL gap_early_start: got %b expected 0", bus.start_fft); end
            acc += int'(v);
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if (bus.start_fft !== 1'b1 || bus.in_ctrl_all_in !== 1'b0) begin n_fail++; $display("FAIL gap_launch: got start=%b ctrl=%b expected 1,0", bus.start_fft, bus.in_ctrl_all_in); end
        cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_fft_done_ignored;
        load(20);
        cyc(1'b0, 1'b1, 1'b0);
        n_chk++; if (bus.din_ready !== 1'b1 || bus.counter_o !== e_addr(20)) begin n_fail++; $display("FAIL done_in_load: got ready=%b addr=%0d expected 1,%0d", bus.din_ready, bus.counter_o, e_addr(20)); end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if (bus.counter_o !== e_addr(20)) begin n_fail++; $display("FAIL done_load_hold: got %0d expected %0d", bus.counter_o, e_addr(20)); end
        load(44);
        cyc(1'b0, 1'b1, 1'b0);
        n_chk++; if (bus.start_fft !== 1'b1) begin n_fail++; $display("FAIL done_launch_start: got %b expected 1", bus.start_fft); end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if (bus.din_ready !== 1'b0 || bus.start_fft !== 1'b0) begin n_fail++; $display("FAIL done_in_launch: got ready=%b start=%b expected 0,0", bus.din_ready, bus.start_fft); end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if (bus.din_ready !== 1'b1 || bus.in_ctrl_all_in !== 1'b1 || bus.counter_o !== 6'd0) begin n_fail++; $display("FAIL done_in_busy: got ready=%b ctrl=%b addr=%0d expected 1,1,0", bus.din_ready, bus.in_ctrl_all_in, bus.counter_o); end
        for (int k = 0; k < 64; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            n_chk++; if (bus.counter_o !== e_addr(k) || bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL frame2_addr[%0d]: got %0d wr=%b expected %0d wr=1", k, bus.counter_o, bus.wr_en, e_addr(k)); end
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if (bus.start_fft !== 1'b1) begin n_fail++; $display("FAIL frame2_start: got %b expected 1", bus.start_fft); end
        cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_drop;
        load(64);
        cyc(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            n_chk++; if (bus.wr_en !== 1'b0 || bus.counter_o !== 6'd0) begin n_fail++; $display("FAIL drop_wr[%0d]: got wr=%b addr=%0d expected 0,0", k, bus.wr_en, bus.counter_o); end
            n_chk++; if (bus.drop_err !== (k != 0)) begin n_fail++; $display("FAIL drop_flag[%0d]: got %b expected %b", k, bus.drop_err, k != 0); end
        end
        cyc(1'b0, 1'b1, 1'b0);
        load(64);
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if (bus.drop_err !== 1'b1 || bus.start_fft !== 1'b1) begin n_fail++; $display("FAIL drop_sticky: got drop=%b start=%b expected 1,1", bus.drop_err, bus.start_fft); end
        cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid;
        int st_cnt = 0;
        load(37);
        n_chk++; if (bus.counter_o !== e_addr(36)) begin n_fail++; $display("FAIL mid_addr: got %0d expected %0d", bus.counter_o, e_addr(36)); end
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if (bus.counter_o !== 6'd0 || bus.din_ready !== 1'b1 || bus.drop_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got addr=%0d ready=%b drop=%b expected 0,1,0", bus.counter_o, bus.din_ready, bus.drop_err); end
        for (int k = 0; k < 68; k++) begin
            cyc(k < 64, 1'b0, 1'b0);
            st_cnt += int'(bus.start_fft);
        end
        n_chk++; if (st_cnt != 1) begin n_fail++; $display("FAIL mid_start_count: got %0d expected 1", st_cnt); end
    endtask

    task automatic test_rst_and_done;
        int st_cnt = 0;
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        n_chk++; if (bus.din_ready !== 1'b1 || bus.in_ctrl_all_in !== 1'b1 || bus.counter_o !== 6'd0 || bus.drop_err !== 1'b0) begin n_fail++; $display("FAIL rstdone_state: got ready=%b ctrl=%b addr=%0d drop=%b expected 1,1,0,0", bus.din_ready, bus.in_ctrl_all_in, bus.counter_o, bus.drop_err); end
        for (int k = 0; k < 4; k++) begin
            st_cnt += int'(bus.start_fft);
            cyc(1'b0, 1'b0, 1'b0);
        end
        n_chk++; if (st_cnt != 0) begin n_fail++; $display("FAIL rstdone_start: got %0d expected 0", st_cnt); end
    endtask

    task automatic test_random;
        for (int k = 0; k < 1500; k++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
            if (!rst) begin
                n_chk++;
                if (bus.din_ready !== (m_ph == 0) || bus.in_ctrl_all_in !== (m_ph == 0) || bus.start_fft !== (m_ph == 1) ||
                    bus.drop_err !== m_drop || bus.counter_o !== e_addr(m_cnt) ||
                    bus.wr_en !== (bus.din_valid && m_ph == 0) || bus.hold_all_in !== !(bus.din_valid && m_ph == 0)) begin
                    n_fail++;
                    $display("FAIL rand[%0d]: got rdy=%b ctl=%b st=%b drop=%b addr=%0d wr=%b hold=%b expected phase=%0d drop=%b addr=%0d",
                             k, bus.din_ready, bus.in_ctrl_all_in, bus.start_fft, bus.drop_err, bus.counter_o, bus.wr_en,
                             bus.hold_all_in, m_ph, m_drop, e_addr(m_cnt));
                end
            end
        end
    endtask

    initial begin
        bus.din_valid = 1'b0;
        bus.fft_done  = 1'b0;
        test_reset;
        test_back_to_back;
        test_gaps;
        test_fft_done_ignored;
        test_drop;
        test_reset_mid;
        test_rst_and_done;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
